// File: rtl/reg32t_bank_ctrl.sv
// Serialises word commands into a bank of triplicated 32-bit serial-load registers and
// deserialises readback; a write takes 35 cycles from acceptance to ready again, a read 35, a bad address 2.
module reg32t_bank_ctrl #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            bclk,
    input  logic            rst,
    input  logic            cmdValid,
    output logic            cmdReady,
    input  logic            cmdWrite,
    input  logic [AW-1:0]   cmdAddr,
    input  logic [31:0]     cmdData,
    output logic            rspValid,
    output logic            rspErr,
    output logic [31:0]     rspData,
    output logic [NREG-1:0] shiftEn,
    output logic [NREG-1:0] latchIn,
    output logic [NREG-1:0] latchOut,
    output logic            shiftIn,
    input  logic            shiftOut,
    input  logic            serIn,
    input  logic            seuClear,
    output logic            seuFlag,
    output logic [7:0]      seuCount
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WSHIFT = 3'd1,
        WLATCH = 3'd2,
        RLOAD  = 3'd3,
        RSHIFT = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic            err_q, err_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [31:0]     rd_q, rd_d;
    logic            ser_q;
    logic            flag_q, flag_d;
    logic [7:0]      count_q, count_d;
    logic [NREG-1:0] sel;
    logic            rise;

    always_ff @(posedge bclk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            ser_q   <= 1'b0;
            flag_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            ser_q   <= serIn;
            flag_q  <= flag_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (cmdValid) begin
                    wr_d   = cmdWrite;
                    addr_d = cmdAddr;
                    data_d = cmdData;
                    cnt_d  = '0;
                    if (32'(cmdAddr) >= 32'(NREG)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = cmdWrite ? WSHIFT : RLOAD;
                    end
                end
            end
            WSHIFT: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    cnt_d   = '0;
                    state_d = WLATCH;
                end
            end
            WLATCH: state_d = DONE;
            RLOAD: begin
                cnt_d   = '0;
                state_d = RSHIFT;
            end
            RSHIFT: begin
                rd_d  = {rd_q[30:0], shiftOut};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode of the latched address; an out-of-range index selects nothing.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NREG; i++) begin
            sel[i] = (addr_q == AW'(i));
        end
    end

    always_comb begin
        cmdReady = (state_q == IDLE);
        rspValid = (state_q == DONE);
        rspErr   = (state_q == DONE) && err_q;
        rspData  = ((state_q == DONE) && !wr_q && !err_q) ? rd_q : '0;
        shiftEn  = ((state_q == WSHIFT) || (state_q == RSHIFT)) ? sel : '0;
        latchIn  = (state_q == WLATCH) ? sel : '0;
        latchOut = (state_q == RLOAD) ? sel : '0;
        shiftIn  = (state_q == WSHIFT) ? data_q[5'd31 - cnt_q[4:0]] : 1'b0;
    end

    // A clear coinciding with a new rising edge keeps that edge as the first event.
    always_comb begin
        rise    = serIn & ~ser_q;
        flag_d  = flag_q;
        count_d = count_q;
        if (seuClear) begin
            flag_d  = rise;
            count_d = {7'd0, rise};
        end else if (rise) begin
            flag_d  = 1'b1;
            count_d = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
        end
    end

    assign seuFlag  = flag_q;
    assign seuCount = count_q;

endmodule

// File: tb/tb_reg32t_bank_ctrl.sv
// Bench for reg32t_bank_ctrl: serial bank model, timeline-based expectations, SEU counter model.
module tb_reg32t_bank_ctrl;
    localparam int NREG = 32;
    localparam int AW   = 6;

    logic            bclk;
    logic            rst;
    logic            cmdValid;
    logic            cmdReady;
    logic            cmdWrite;
    logic [AW-1:0]   cmdAddr;
    logic [31:0]     cmdData;
    logic            rspValid;
    logic            rspErr;
    logic [31:0]     rspData;
    logic [NREG-1:0] shiftEn;
    logic [NREG-1:0] latchIn;
    logic [NREG-1:0] latchOut;
    logic            shiftIn;
    logic            shiftOut;
    logic            serIn;
    logic            seuClear;
    logic            seuFlag;
    logic [7:0]      seuCount;

    reg32t_bank_ctrl #(.NREG(NREG), .AW(AW)) dut (
        .bclk(bclk), .rst(rst),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
        .cmdAddr(cmdAddr), .cmdData(cmdData),
        .rspValid(rspValid), .rspErr(rspErr), .rspData(rspData),
        .shiftEn(shiftEn), .latchIn(latchIn), .latchOut(latchOut),
        .shiftIn(shiftIn), .shiftOut(shiftOut),
        .serIn(serIn), .seuClear(seuClear),
        .seuFlag(seuFlag), .seuCount(seuCount)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    // Register bank model: per-register shifter and holding register.
    logic [31:0] bsh  [NREG];
    logic [31:0] breg [NREG];
    logic        bank_clr;

    always @(posedge bclk) begin
        for (int i = 0; i < NREG; i++) begin
            if (bank_clr) begin
                bsh[i]  <= '0;
                breg[i] <= '0;
            end else begin
                if (latchOut[i])     bsh[i] <= breg[i];
                else if (shiftEn[i]) bsh[i] <= {bsh[i][30:0], shiftIn};
                if (latchIn[i])      breg[i] <= bsh[i];
            end
        end
    end

    always_comb begin
        shiftOut = 1'b0;
        for (int i = 0; i < NREG; i++)
            if (shiftEn[i]) shiftOut = shiftOut | bsh[i][31];
    end

    logic [127:0] obs_v;
    assign obs_v = {28'd0, cmdReady, rspValid, rspErr, shiftIn, shiftEn, latchIn, latchOut};

    logic [31:0] mem_exp [NREG];
    int n_chk = 0;
    int n_err = 0;
    int cmd_no = 0;
    int exp_cnt = 0;
    bit exp_flag = 1'b0;
    bit prev_ser = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack(bit rdy, bit vld, bit err, bit si,
                                          logic [31:0] se, logic [31:0] li, logic [31:0] lo);
        return {28'd0, rdy, vld, err, si, se, li, lo};
    endfunction

    task automatic step();
        @(posedge bclk);
        #1;
    endtask

    // Issue one command and check every cycle up to the return to IDLE.
    task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [31:0] data,
                           input bit nq, input bit nwr, input logic [AW-1:0] naddr,
                           input logic [31:0] ndata);
        int guard;
        int len;
        bit oor;
        logic [31:0] oh;
        logic [127:0] e;
        logic [31:0] exp_rsp;
        guard = 0;
        while (!cmdReady && guard < 100) begin
            step();
            guard++;
        end
        chk("ready_wait", 128'(guard < 100), 128'(1));
        cmd_no++;
        oor = (int'(addr) >= NREG);
        oh  = oor ? 32'd0 : (32'd1 << addr);
        len = oor ? 1 : 34;
        cmdValid = 1'b1;
        cmdWrite = wr;
        cmdAddr  = addr;
        cmdData  = data;
        step();
        if (nq) begin
            cmdWrite = nwr;
            cmdAddr  = naddr;
            cmdData  = ndata;
        end else begin
            cmdValid = 1'b0;
        end
        for (int k = 1; k <= len; k++) begin
            if (oor)               e = pack(0, 1, 1, 0, 0, 0, 0);
            else if (wr && k <= 32) e = pack(0, 0, 0, data[32-k], oh, 0, 0);
            else if (wr && k == 33) e = pack(0, 0, 0, 0, 0, oh, 0);
            else if (!wr && k == 1) e = pack(0, 0, 0, 0, 0, 0, oh);
            else if (!wr && k <= 33) e = pack(0, 0, 0, 0, oh, 0, 0);
            else                   e = pack(0, 1, 0, 0, 0, 0, 0);
            chk($sformatf("cmd%0d_cyc%0d", cmd_no, k), obs_v, e);
            if (k == len) begin
                exp_rsp = 32'd0;
                if (!wr && !oor) exp_rsp = mem_exp[addr];
                chk($sformatf("cmd%0d_rspdata", cmd_no), 128'(rspData), 128'(exp_rsp));
            end
            step();
        end
        chk($sformatf("cmd%0d_idle", cmd_no), obs_v, pack(1, 0, 0, 0, 0, 0, 0));
        if (wr && !oor) begin
            mem_exp[addr] = data;
            chk($sformatf("cmd%0d_bank", cmd_no), 128'(breg[addr]), 128'(data));
        end
    endtask

    task automatic seu_cycle(input bit s, input bit c);
        bit r;
        serIn    = s;
        seuClear = c;
        step();
        r = s && !prev_ser;
        prev_ser = s;
        if (c) begin
            exp_flag = r;
            exp_cnt  = r ? 1 : 0;
        end else if (r) begin
            exp_flag = 1'b1;
            exp_cnt  = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
        end
    endtask

    initial begin
        int bad;
        rst = 1'b1; cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdData = '0;
        serIn = 1'b0; seuClear = 1'b0; bank_clr = 1'b1;
        for (int i = 0; i < NREG; i++) mem_exp[i] = 32'd0;
        step();
        step();
        bank_clr = 1'b0;
        chk("rst_outputs", obs_v, pack(1, 0, 0, 0, 0, 0, 0));
        chk("rst_rspdata", 128'(rspData), 128'(0));
        chk("rst_seu", 128'({seuFlag, seuCount}), 128'(0));
        rst = 1'b0;
        step();

        run_cmd(1, 6'd3, 32'hA5A50F0F, 0, 0, 0, 0);
        run_cmd(0, 6'd3, 32'h0, 0, 0, 0, 0);
        chk("read3_value", 128'(rspData), 128'(0));
        run_cmd(1, 6'd0, 32'hDEADBEEF, 0, 0, 0, 0);
        run_cmd(1, 6'(NREG-1), 32'hDEADBEEF, 0, 0, 0, 0);
        run_cmd(0, 6'd0, 32'h0, 0, 0, 0, 0);
        run_cmd(0, 6'(NREG-1), 32'h0, 0, 0, 0, 0);

        run_cmd(1, 6'd40, 32'hFFFFFFFF, 0, 0, 0, 0);
        run_cmd(0, 6'd40, 32'h0, 0, 0, 0, 0);
        bad = 0;
        for (int i = 0; i < NREG; i++) if (breg[i] !== mem_exp[i]) bad++;
        chk("oor_bank_unchanged", 128'(bad), 128'(0));

        run_cmd(1, 6'd7, 32'h13579BDF, 1, 0, 6'd7, 32'h0);
        run_cmd(0, 6'd7, 32'h0, 0, 0, 0, 0);

        run_cmd(1, 6'd5, 32'h0BADF00D, 0, 0, 0, 0);
        cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 6'd5; cmdData = 32'h12345678;
        step();
        cmdValid = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        chk("rst_abort_outputs", obs_v, pack(1, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (latchIn != '0) chk("rst_abort_latch", 128'(latchIn), 128'(0));
            step();
        end
        chk("rst_abort_bank", 128'(breg[5]), 128'(32'h0BADF00D));
        run_cmd(0, 6'd5, 32'h0, 0, 0, 0, 0);

        for (int n = 0; n < 12; n++) begin
            run_cmd(1'($urandom_range(0, 1)), 6'($urandom_range(0, 47)), $urandom, 0, 0, 0, 0);
        end
        for (int n = 0; n < 4; n++) begin
            run_cmd(0, 6'($urandom_range(0, NREG-1)), 32'h0, 0, 0, 0, 0);
        end

        seu_cycle(1, 0); seu_cycle(0, 0);
        seu_cycle(1, 0); seu_cycle(0, 0);
        chk("seu_two_flag", 128'(seuFlag), 128'(1));
        chk("seu_two_cnt", 128'(seuCount), 128'(2));
        seu_cycle(1, 1);
        chk("seu_clr_rise", 128'({seuFlag, seuCount}), 128'({1'b1, 8'd1}));
        seu_cycle(0, 0);
        seu_cycle(0, 1);
        chk("seu_clear", 128'({seuFlag, seuCount}), 128'(0));
        for (int n = 0; n < 300; n++) begin
            seu_cycle(1, 0);
            seu_cycle(0, 0);
        end
        chk("seu_saturate", 128'(seuCount), 128'(255));
        chk("seu_sat_model", 128'({seuFlag, seuCount}), 128'({exp_flag, 8'(exp_cnt)}));
        seu_cycle(0, 1);
        for (int n = 0; n < 150; n++) begin
            seu_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            chk($sformatf("seu_rand%0d", n), 128'({seuFlag, seuCount}),
                128'({exp_flag, 8'(exp_cnt)}));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
